led_blink: RTL and testbench
============================

LED_BLINK -- requirements
Module: led_blink

Interface
REQ-001 Parameter DIV, default 62500000, clock cycles per LED step (0.5 s at 125 MHz); legal range 1 to 2^32-1.
REQ-002 Parameter CNT_W, default 32, prescaler width; SHALL be wide enough to hold DIV-1.
REQ-003 Port sysclk, input, 1 bit, sole clock, all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 Port led, output, 4 bits, LED drive pattern, driven directly from a register.
REQ-006 One clock domain (sysclk); reset asynchronous, active-high.

Function
REQ-007 Prescaler register SHALL count 0, 1, ..., DIV-1 and then return to 0, advancing one per sysclk cycle.
REQ-008 Internal tick SHALL be asserted in the cycle where the prescaler equals DIV-1.
REQ-009 Internal 4-bit step counter SHALL increment by 1 on each tick edge.
REQ-010 Step counter SHALL wrap 1111 -> 0000 with no stall or flag.
REQ-011 With DIV=1, tick SHALL be asserted every cycle, so the step counter advances every clock.
REQ-012 led SHALL change only on a tick edge and SHALL hold its value between ticks.
REQ-013 After reset release, the first led change SHALL occur on the DIV-th rising edge of sysclk; later changes follow every DIV edges.
REQ-014 Free-running behaviour: no enable, no pause, no input other than rst affects the sequence.
REQ-015 Prescaler compare SHALL use the full CNT_W width with no truncation of DIV-1.

Reset
REQ-016 rst high SHALL immediately (asynchronously) clear the prescaler to 0, the step counter to 0, and led to 0000.
REQ-017 While rst is high, all state SHALL hold at its reset value regardless of sysclk.
REQ-018 Reset asserted mid-count SHALL abort the current period.
REQ-019 Counting SHALL restart from prescaler 0 on the first rising edge after rst deasserts.
REQ-020 Deassertion timing is the system's responsibility; the block SHALL NOT contain a reset synchronizer.

Configuration
REQ-021 Macro LED_BLINK_GRAY_EN, when defined, SHALL make led = step ^ (step >> 1), i.e. 4-bit Gray code, so exactly one LED toggles per tick.
REQ-022 Gray encoding SHALL be registered so that led remains glitch-free and updates on the same edge as the step counter.
REQ-023 Without LED_BLINK_GRAY_EN, led SHALL equal the binary step counter.
REQ-024 Reset value of led SHALL be 0000 in both builds.

Verification
REQ-025 DIV=4, rst high 20 ns then low, 125 MHz clock -> led = 0000 for edges 1-3, 0001 at edge 4, 0010 at edge 8, 0011 at edge 12.
REQ-026 DIV=1, run 17 edges after reset -> led steps 0001 ... 1111 over edges 1-15, then 0000 at edge 16 (wrap), then 0001 at edge 17.
REQ-027 DIV=4, assert rst asynchronously at a time with no clock edge while led = 0101 -> led = 0000 immediately; after release, first change to 0001 occurs at edge 4.
REQ-028 LED_BLINK_GRAY_EN defined, DIV=2 -> led sequence 0000, 0001, 0011, 0010, 0110, ... every 2 edges, with exactly one bit changing per step.
REQ-029 Default DIV, 1 us run (125 edges) -> led constant 0000; no X on led after reset.

Source files
------------

// File: rtl/led_blink.sv
// Free-running 4-bit LED stepper: a prescaler divides sysclk by DIV, each tick advances the step.
// Define LED_BLINK_GRAY_EN to drive led with the Gray-coded step instead of the binary step.
module led_blink #(
  parameter int unsigned DIV   = 32'd62500000,
  parameter int unsigned CNT_W = 32
) (
  input  logic       sysclk,
  input  logic       rst,
  output logic [3:0] led
);

  // Terminal count kept at full prescaler width so the compare never drops bits.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIV - 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       led_q, led_d;
  logic             tick;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    step_d = step_q;
    if (tick) begin
      step_d = step_q + 4'd1;
    end
  end

  // Encoding is derived from step_d so led lands on the same edge as the step counter.
`ifdef LED_BLINK_GRAY_EN
  always_comb begin
    led_d = step_d ^ (step_d >> 1);
  end
`else
  always_comb begin
    led_d = step_d;
  end
`endif

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 4'd0;
      led_q  <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_blink.sv
// Directed bench for led_blink: four instances (DIV=4, 1, 2 and default) share one clock.
// Expected patterns follow the build: Gray-coded when LED_BLINK_GRAY_EN is defined.
module tb_led_blink;

  logic       clk;
  logic       rst4, rst1, rst2, rstd;
  logic [3:0] led4, led1, led2, ledd;

  int checks   = 0;
  int failures = 0;
  int e4       = 0;

  led_blink #(.DIV(4), .CNT_W(8)) u_div4 (.sysclk(clk), .rst(rst4), .led(led4));
  led_blink #(.DIV(1), .CNT_W(4)) u_div1 (.sysclk(clk), .rst(rst1), .led(led1));
  led_blink #(.DIV(2), .CNT_W(4)) u_div2 (.sysclk(clk), .rst(rst2), .led(led2));
  led_blink u_divd (.sysclk(clk), .rst(rstd), .led(ledd));

  // 125 MHz
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  function automatic logic [3:0] enc(input logic [3:0] s);
`ifdef LED_BLINK_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    rstd = 1'b1;
    #19;
    check("rst_div4", led4, 4'h0);
    check("rst_div1", led1, 4'h0);
    check("rst_div2", led2, 4'h0);
    check("rst_divd", ledd, 4'h0);
    #1;
    // Release away from a rising edge.
    @(negedge clk);
    rst4 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    rstd = 1'b0;

    for (int n = 1; n <= 130; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n <= 17) check("div1_step", led1, enc(4'(n)));
      if (n <= 20) check("div2_step", led2, enc(4'(n / 2)));
      if (n <= 125) check("divdef_const", ledd, 4'h0);
      if (rst4) begin
        check("div4_hold", led4, 4'h0);
      end else begin
        e4++;
        check("div4_step", led4, enc(4'(e4 / 4)));
      end
      if (n == 21) begin
        check("div4_pre_rst", led4, enc(4'd5));
        #1 rst4 = 1'b1;
        #1 check("div4_async_clr", led4, 4'h0);
      end
      if (n == 24) begin
        rst4 = 1'b0;
        e4   = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
